// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: RV32I issue/decode stage driving a combinational ALU and returning writeback or branch results.
module alu_issue_ctrl #(
    parameter int D_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_instr,
    output logic               alusrc,
    output logic [3:0]         aluctrl,
    output logic [D_WIDTH-1:0] immop,
    input  logic [D_WIDTH-1:0] aluout,
    input  logic               eq,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [D_WIDTH-1:0] res_data,
    output logic [4:0]         res_rd,
    output logic               res_wen,
    output logic               br_valid,
    output logic               br_taken,
    output logic               illegal
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state;
    logic [6:0] opc;
    logic [2:0] f3;
    logic f7b, is_op, is_imm, is_br, shift, bad, wr, br_neg;
    logic [3:0] d_aluctrl;
    logic [D_WIDTH-1:0] d_immop;
    assign opc = in_instr[6:0];
    assign f3 = in_instr[14:12];
    assign f7b = in_instr[30];
    always_comb begin
        is_op = opc == 7'b0110011;
        is_imm = opc == 7'b0010011;
        is_br = opc == 7'b1100011;
        shift = f3[1:0] == 2'b01;
        bad = !(is_op || is_imm || is_br)
            || (is_op && f7b && f3 != 3'b000 && f3 != 3'b101)
            || (is_imm && f7b && f3 == 3'b001)
            || (is_br && f3[2:1] == 2'b01);
        wr = (is_op || is_imm) && !bad;
        // branches reuse the compare ops; odd f3 inverts the flag
        d_aluctrl = bad ? 4'b0000
                  : is_br ? (f3[2] ? {3'b001, f3[1]} : 4'b0100)
                  : (is_op || shift) ? {f7b, f3} : {1'b0, f3};
        d_immop = (!is_imm || bad) ? '0
                : shift ? {{(D_WIDTH-5){1'b0}}, in_instr[24:20]}
                : {{(D_WIDTH-12){in_instr[31]}}, in_instr[31:20]};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            in_ready <= 1'b1;
            alusrc <= 1'b0;
            aluctrl <= '0;
            immop <= '0;
            res_valid <= 1'b0;
            res_data <= '0;
            res_rd <= '0;
            res_wen <= 1'b0;
            br_valid <= 1'b0;
            br_taken <= 1'b0;
            illegal <= 1'b0;
            br_neg <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    state <= EXEC;
                    in_ready <= 1'b0;
                    alusrc <= is_imm && !bad;
                    aluctrl <= d_aluctrl;
                    immop <= d_immop;
                    res_rd <= wr ? in_instr[11:7] : 5'd0;
                    res_wen <= wr;
                    br_valid <= is_br && !bad;
                    br_neg <= f3[0];
                    br_taken <= 1'b0;
                    illegal <= bad;
                end
                EXEC: begin
                    state <= RESP;
                    res_data <= aluout;
                    br_taken <= br_valid && (eq ^ br_neg);
                    res_valid <= 1'b1;
                end
                RESP: if (res_ready) begin
                    state <= IDLE;
                    res_valid <= 1'b0;
                    in_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed vectors with a response scoreboard checked by an independent monitor.
module tb_alu_issue_ctrl;
    logic clk = 0, rst_n = 0, in_valid = 0, res_ready = 0, eq = 0;
    logic [31:0] in_instr = 0, aluout = 0;
    logic in_ready, alusrc, res_valid, res_wen, br_valid, br_taken, illegal;
    logic [3:0] aluctrl;
    logic [31:0] immop, res_data;
    logic [4:0] res_rd;

    alu_issue_ctrl #(.D_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .alusrc(alusrc), .aluctrl(aluctrl), .immop(immop), .aluout(aluout), .eq(eq),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_rd(res_rd),
        .res_wen(res_wen), .br_valid(br_valid), .br_taken(br_taken), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr, aout;
        logic e, src;
        logic [3:0] ctrl;
        logic [31:0] imm;
        logic [4:0] rd;
        logic wen, bv, bt, ill;
    } vec_t;

    vec_t sb[$];
    vec_t mv;
    int n_cmp = 0, n_err = 0, n_resp = 0, n_push = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] ex);
        n_cmp++;
        if (act !== ex) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, ex);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 1, 0);
            end else begin
                mv = sb.pop_front();
                n_resp++;
                chk("res_data", res_data, mv.aout);
                chk("res_rd", res_rd, mv.rd);
                chk("res_wen", res_wen, mv.wen);
                chk("br_valid", br_valid, mv.bv);
                chk("br_taken", br_taken, mv.bt);
                chk("illegal", illegal, mv.ill);
                chk("resp_alusrc", alusrc, mv.src);
                chk("resp_aluctrl", aluctrl, mv.ctrl);
                chk("resp_immop", immop, mv.imm);
            end
        end
    end

    task automatic chk_rst(string nm);
        chk({nm, "_ctl"}, {in_ready, res_valid, alusrc, aluctrl, res_rd, res_wen, br_valid, br_taken, illegal},
            {1'b1, 1'b0, 1'b0, 4'b0, 5'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        chk({nm, "_immop"}, immop, 0);
        chk({nm, "_res_data"}, res_data, 0);
    endtask

    // Called #1 after a rising edge with the DUT idle.
    task automatic run(input logic [31:0] instr, input logic [31:0] aout, input logic e,
                       input logic src, input logic [3:0] ctrl, input logic [31:0] imm,
                       input logic [4:0] rd, input logic wen, input logic bv, input logic bt,
                       input logic ill, input int hold, input bit b2b);
        vec_t v;
        logic [63:0] snap;
        v = '{instr, aout, e, src, ctrl, imm, rd, wen, bv, bt, ill};
        chk("idle_in_ready", in_ready, 1);
        in_valid = 1; in_instr = instr; aluout = aout; eq = e; res_ready = 0;
        @(posedge clk);
        sb.push_back(v);
        n_push++;
        #1;
        if (b2b) in_instr = 32'h00100093;
        else in_valid = 0;
        @(negedge clk);
        chk("exec_ready_valid", {in_ready, res_valid}, 2'b00);
        chk("exec_ctl", {alusrc, aluctrl}, {src, ctrl});
        chk("exec_immop", immop, imm);
        @(posedge clk); #1;
        chk("latency_res_valid", res_valid, 1);
        snap = {res_valid, alusrc, aluctrl, res_rd, res_wen, br_valid, br_taken, illegal, res_data};
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("bp_in_ready", in_ready, 0);
            chk("bp_stable", {res_valid, alusrc, aluctrl, res_rd, res_wen, br_valid, br_taken, illegal, res_data}, snap);
        end
        res_ready = 1;
        @(posedge clk); #1;
        res_ready = 0; in_valid = 0;
        chk("post_hs_ready_valid", {in_ready, res_valid}, 2'b10);
        if (b2b) chk("no_early_accept", aluctrl, ctrl);
    endtask

    // Start an ADDI, then reset asynchronously in EXEC (phase 0) or RESP (phase 1).
    task automatic reset_in(input int phase);
        in_valid = 1; in_instr = 32'hFFF00293; aluout = 32'hFFFFFFFF; eq = 0; res_ready = 0;
        @(posedge clk); #1;
        in_valid = 0;
        if (phase == 1) begin
            @(posedge clk); #1;
            chk("pre_reset_resp", {res_valid, res_data}, {1'b1, 32'hFFFFFFFF});
        end
        #2 rst_n = 0;
        #1 chk_rst(phase == 0 ? "rst_exec" : "rst_resp");
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 chk_rst("por");
        rst_n = 1;
        @(posedge clk); #1;
        //    instr         aluout        eq src ctrl     immop         rd  wen bv bt ill hold b2b
        run(32'hFFF00293, 32'hFFFFFFFF, 0, 1, 4'b0000, 32'hFFFFFFFF, 5, 1, 0, 0, 0, 0, 0);
        run(32'h402081B3, 32'h12345678, 0, 0, 4'b1000, 32'h0,        3, 1, 0, 0, 0, 5, 1);
        run(32'h4040D093, 32'h0000ABCD, 0, 1, 4'b1101, 32'h4,        1, 1, 0, 0, 0, 0, 0);
        run(32'h7FF0E393, 32'h00000F0F, 0, 1, 4'b0110, 32'h7FF,      7, 1, 0, 0, 0, 1, 0);
        run(32'h00208033, 32'h00000003, 0, 0, 4'b0000, 32'h0,        0, 1, 0, 0, 0, 0, 0);
        run(32'h00209063, 32'h00000000, 1, 0, 4'b0100, 32'h0,        0, 0, 1, 0, 0, 0, 0);
        run(32'h00208063, 32'h00000000, 1, 0, 4'b0100, 32'h0,        0, 0, 1, 1, 0, 0, 0);
        run(32'h0020C063, 32'h00000001, 1, 0, 4'b0010, 32'h0,        0, 0, 1, 1, 0, 0, 0);
        run(32'h0020D063, 32'h00000001, 1, 0, 4'b0010, 32'h0,        0, 0, 1, 0, 0, 0, 0);
        run(32'h0020E063, 32'h00000000, 0, 0, 4'b0011, 32'h0,        0, 0, 1, 0, 0, 0, 0);
        run(32'h0020F063, 32'h00000000, 0, 0, 4'b0011, 32'h0,        0, 0, 1, 1, 0, 2, 0);
        run(32'h0000007F, 32'hDEADBEEF, 1, 0, 4'b0000, 32'h0,        0, 0, 0, 0, 1, 0, 0);
        run(32'h40209033, 32'h00000055, 1, 0, 4'b0000, 32'h0,        0, 0, 0, 0, 1, 0, 0);
        run(32'h0020A063, 32'h00000000, 1, 0, 4'b0000, 32'h0,        0, 0, 0, 0, 1, 0, 0);
        reset_in(0);
        run(32'h4040D093, 32'h00000007, 0, 1, 4'b1101, 32'h4,        1, 1, 0, 0, 0, 0, 0);
        reset_in(1);
        run(32'hFFF00293, 32'hFFFFFFFF, 0, 1, 4'b0000, 32'hFFFFFFFF, 5, 1, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        chk("resp_count", n_resp, n_push);
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
